// File: rtl/instr_mem_pipe.sv
// ----------------------------------------------------------------------------
// instr_mem_pipe
//   Instruction memory with a one-entry registered fetch response and a
//   byte-enabled program-loader write port.
//
//   Parameters
//     DEPTH        memory size in 32-bit words (power of two, 4..4096)
//     FAULT_INSTR  instruction returned for a misaligned / out-of-range fetch
//
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     f_req        fetch request valid
//     f_addr       fetch byte address
//     f_ready      request accepted this cycle (response slot free or draining)
//     f_rvalid     response register holds a response
//     f_rdata      fetched word (little-endian)
//     f_fault      held response is a faulting fetch
//     f_rready     consumer takes the response this cycle
//     ld_we        loader write strobe
//     ld_addr      loader word index
//     ld_wdata     loader write data
//     ld_be        loader byte enables (bit k -> bits 8k+7:8k)
// ----------------------------------------------------------------------------
module instr_mem_pipe #(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] FAULT_INSTR = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     f_req,
    input  logic [31:0]              f_addr,
    output logic                     f_ready,
    output logic                     f_rvalid,
    output logic [31:0]              f_rdata,
    output logic                     f_fault,
    input  logic                     f_rready,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_wdata,
    input  logic [3:0]               ld_be
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

    logic [31:0] r_mem [DEPTH];
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_fault;

    logic        w_ready;
    logic        w_accept;
    logic        w_fault;
    logic [31:0] w_rdword;

    // The slot can take a new fetch when empty or when its current
    // occupant leaves this same cycle.
    assign w_ready  = !r_rvalid || f_rready;
    assign w_accept = f_req && w_ready;
    assign w_fault  = (f_addr[1:0] != 2'b00) || (f_addr >= LIMIT);
    assign w_rdword = r_mem[f_addr[AW+1:2]];

    // Loader port. Memory is not cleared by reset; the reset term only
    // blocks writes while reset is held. Because the response register
    // samples w_rdword at the same edge the write lands, a same-cycle
    // fetch of the written word sees the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else if (ld_we) begin
            for (int k = 0; k < 4; k++) begin
                if (ld_be[k]) r_mem[ld_addr][8*k +: 8] <= ld_wdata[8*k +: 8];
            end
        end
    end

    // One-entry response register: EMPTY when r_rvalid=0, FULL otherwise.
    // Data and fault flag only move on an accepted fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'h0;
            r_fault  <= 1'b0;
        end else if (w_accept) begin
            r_rvalid <= 1'b1;
            r_fault  <= w_fault;
            r_rdata  <= w_fault ? FAULT_INSTR : w_rdword;
        end else if (f_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign f_ready  = w_ready;
    assign f_rvalid = r_rvalid;
    assign f_rdata  = r_rdata;
    assign f_fault  = r_fault;

endmodule
